// File: rtl/rom_access_ctrl_pkg.sv
// Shared types and helpers for the PSRAM access sequencer: FSM states,
// default cycle timings and byte-lane selection.
package rom_access_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SNES_RD,
        SNES_WR,
        MCU_RD,
        MCU_WR
    } state_t;

    localparam int DEF_RD_CYCLES  = 7;
    localparam int DEF_WR_CYCLES  = 6;
    localparam int DEF_SYNC_DEPTH = 3;

    typedef struct packed {
        logic bhe_n;
        logic ble_n;
    } lane_t;

    // Even byte addresses live in the upper half of the 16-bit word.
    function automatic lane_t lane_sel(input logic addr_lsb);
        lane_t l;
        l.bhe_n = addr_lsb;
        l.ble_n = ~addr_lsb;
        return l;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic addr_lsb);
        return addr_lsb ? word[7:0] : word[15:8];
    endfunction

endpackage

// File: rtl/rom_access_ctrl_snes_strobe_sync.sv
// Synchroniser and falling-edge detector for one active-low SNES strobe.
// ROM_STROBE_FILTER_EN additionally demands two consecutive low samples.
module snes_strobe_sync #(
    parameter int SYNC_DEPTH = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_n_i,
    output logic assert_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;
`ifdef ROM_STROBE_FILTER_EN
    logic                  prev2_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
`ifdef ROM_STROBE_FILTER_EN
            prev2_q <= 1'b1;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_DEPTH-2:0], strobe_n_i};
            prev_q  <= sync_q[SYNC_DEPTH-1];
`ifdef ROM_STROBE_FILTER_EN
            prev2_q <= prev_q;
`endif
        end
    end

`ifdef ROM_STROBE_FILTER_EN
    assign assert_o = prev2_q & ~prev_q & ~sync_q[SYNC_DEPTH-1];
`else
    assign assert_o = prev_q & ~sync_q[SYNC_DEPTH-1];
`endif

endmodule

// File: rtl/rom_access_ctrl.sv
// Sequencer turning SNES strobes and MCU byte requests into timed PSRAM cycles,
// SNES having priority. Optional glitch filter: ROM_STROBE_FILTER_EN.
module rom_access_ctrl
    import rom_access_ctrl_pkg::*;
#(
    parameter int RD_CYCLES  = DEF_RD_CYCLES,
    parameter int WR_CYCLES  = DEF_WR_CYCLES,
    parameter int SYNC_DEPTH = DEF_SYNC_DEPTH
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SNES_READ,
    input  logic        SNES_WRITE,
    input  logic [7:0]  SNES_DATA_IN,
    input  logic [23:0] ADDR_IN,
    input  logic        ROM_HIT,
    input  logic        IS_WRITABLE,
    input  logic [23:0] MCU_ADDR,
    input  logic [7:0]  MCU_DOUT,
    input  logic        MCU_RRQ,
    input  logic        MCU_WRQ,
    output logic        MCU_RDY,
    output logic [7:0]  MCU_DINR,
    output logic [7:0]  SNES_DOUT,
    output logic [22:0] ROM_ADDR,
    input  logic [15:0] ROM_DATA_IN,
    output logic [15:0] ROM_DATA_OUT,
    output logic        ROM_DATA_OE,
    output logic        ROM_CE,
    output logic        ROM_OE,
    output logic        ROM_WE,
    output logic        ROM_BHE,
    output logic        ROM_BLE
);

    if (RD_CYCLES < 2 || RD_CYCLES > 15) begin : g_bad_rd
        $error("RD_CYCLES must be in 2..15");
    end
    if (WR_CYCLES < 2 || WR_CYCLES > 15) begin : g_bad_wr
        $error("WR_CYCLES must be in 2..15");
    end
    if (SYNC_DEPTH < 2) begin : g_bad_sync
        $error("SYNC_DEPTH must be at least 2");
    end

    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

    logic rd_evt, wr_evt, rd_req, wr_req, snes_req, mcu_take;

    snes_strobe_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_rd_sync (
        .clk_i(CLK), .rst_i(RST), .strobe_n_i(SNES_READ), .assert_o(rd_evt)
    );
    snes_strobe_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_wr_sync (
        .clk_i(CLK), .rst_i(RST), .strobe_n_i(SNES_WRITE), .assert_o(wr_evt)
    );

    assign rd_req   = rd_evt & ROM_HIT;
    assign wr_req   = wr_evt & ROM_HIT & IS_WRITABLE;
    assign snes_req = rd_req | wr_req;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        snes_pend_q, snes_pend_d, snes_wr_q, snes_wr_d;
    logic [23:0] snes_addr_q, snes_addr_d;
    logic [7:0]  snes_data_q, snes_data_d;
    logic        mcu_pend_q, mcu_pend_d, mcu_wr_q, mcu_wr_d, mcu_rdy_q, mcu_rdy_d;
    logic [23:0] mcu_addr_q, mcu_addr_d;
    logic [7:0]  mcu_data_q, mcu_data_d;
    logic [22:0] rom_addr_q, rom_addr_d;
    logic        lsb_q, lsb_d;
    logic [15:0] rom_dout_q, rom_dout_d;
    logic        ce_q, ce_d, oe_q, oe_d, we_q, we_d, bhe_q, bhe_d, ble_q, ble_d, doe_q, doe_d;
    logic [7:0]  snes_dout_q, snes_dout_d, mcu_dinr_q, mcu_dinr_d;

    logic        start, start_wr;
    logic [23:0] start_addr;
    logic [7:0]  start_data;
    lane_t       lane;

    assign mcu_take = mcu_rdy_q & (MCU_RRQ | MCU_WRQ);

    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        state_d     = state_q;      cnt_d       = cnt_q;
        snes_pend_d = snes_pend_q;  snes_wr_d   = snes_wr_q;
        snes_addr_d = snes_addr_q;  snes_data_d = snes_data_q;
        mcu_pend_d  = mcu_pend_q;   mcu_wr_d    = mcu_wr_q;   mcu_rdy_d = mcu_rdy_q;
        mcu_addr_d  = mcu_addr_q;   mcu_data_d  = mcu_data_q;
        rom_addr_d  = rom_addr_q;   lsb_d       = lsb_q;      rom_dout_d = rom_dout_q;
        ce_d = ce_q; oe_d = oe_q; we_d = we_q; bhe_d = bhe_q; ble_d = ble_q; doe_d = doe_q;
        snes_dout_d = snes_dout_q;  mcu_dinr_d  = mcu_dinr_q;
        start = 1'b0; start_wr = 1'b0; start_addr = '0; start_data = '0;
        lane  = lane_sel(1'b0);

        // Captures always land in the pending slots; a start in IDLE consumes them below.
        if (snes_req) begin
            snes_pend_d = 1'b1;
            snes_wr_d   = wr_req;
            snes_addr_d = ADDR_IN;
            snes_data_d = SNES_DATA_IN;
        end
        if (mcu_take) begin
            mcu_pend_d = 1'b1;
            mcu_wr_d   = MCU_WRQ;
            mcu_addr_d = MCU_ADDR;
            mcu_data_d = MCU_DOUT;
            mcu_rdy_d  = 1'b0;
        end

        if (state_q == IDLE) begin
            if (snes_req || snes_pend_q) begin
                start       = 1'b1;
                start_wr    = snes_req ? wr_req       : snes_wr_q;
                start_addr  = snes_req ? ADDR_IN      : snes_addr_q;
                start_data  = snes_req ? SNES_DATA_IN : snes_data_q;
                snes_pend_d = 1'b0;
                state_d     = start_wr ? SNES_WR : SNES_RD;
            end else if (mcu_pend_q) begin
                start      = 1'b1;
                start_wr   = mcu_wr_q;
                start_addr = mcu_addr_q;
                start_data = mcu_data_q;
                mcu_pend_d = 1'b0;
                state_d    = mcu_wr_q ? MCU_WR : MCU_RD;
            end
        end else if (cnt_q == 4'd0) begin
            state_d = IDLE;
            ce_d = 1'b1; oe_d = 1'b1; we_d = 1'b1; bhe_d = 1'b1; ble_d = 1'b1; doe_d = 1'b0;
            if (state_q == SNES_RD) snes_dout_d = lane_byte(ROM_DATA_IN, lsb_q);
            if (state_q == MCU_RD)  mcu_dinr_d  = lane_byte(ROM_DATA_IN, lsb_q);
            if (state_q == MCU_RD || state_q == MCU_WR) mcu_rdy_d = 1'b1;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end

        if (start) begin
            lane       = lane_sel(start_addr[0]);
            rom_addr_d = start_addr[23:1];
            lsb_d      = start_addr[0];
            rom_dout_d = {start_data, start_data};
            cnt_d      = start_wr ? WR_LOAD : RD_LOAD;
            ce_d  = 1'b0;
            oe_d  = start_wr;
            we_d  = ~start_wr;
            doe_d = start_wr;
            bhe_d = lane.bhe_n;
            ble_d = lane.ble_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;   cnt_q       <= '0;
            snes_pend_q <= 1'b0;   snes_wr_q   <= 1'b0;
            snes_addr_q <= '0;     snes_data_q <= '0;
            mcu_pend_q  <= 1'b0;   mcu_wr_q    <= 1'b0;  mcu_rdy_q <= 1'b1;
            mcu_addr_q  <= '0;     mcu_data_q  <= '0;
            rom_addr_q  <= '0;     lsb_q       <= 1'b0;  rom_dout_q <= '0;
            ce_q <= 1'b1; oe_q <= 1'b1; we_q <= 1'b1; bhe_q <= 1'b1; ble_q <= 1'b1; doe_q <= 1'b0;
            snes_dout_q <= 8'h00;  mcu_dinr_q  <= 8'h00;
        end else begin
            state_q     <= state_d;      cnt_q       <= cnt_d;
            snes_pend_q <= snes_pend_d;  snes_wr_q   <= snes_wr_d;
            snes_addr_q <= snes_addr_d;  snes_data_q <= snes_data_d;
            mcu_pend_q  <= mcu_pend_d;   mcu_wr_q    <= mcu_wr_d;   mcu_rdy_q <= mcu_rdy_d;
            mcu_addr_q  <= mcu_addr_d;   mcu_data_q  <= mcu_data_d;
            rom_addr_q  <= rom_addr_d;   lsb_q       <= lsb_d;      rom_dout_q <= rom_dout_d;
            ce_q <= ce_d; oe_q <= oe_d; we_q <= we_d; bhe_q <= bhe_d; ble_q <= ble_d; doe_q <= doe_d;
            snes_dout_q <= snes_dout_d;  mcu_dinr_q  <= mcu_dinr_d;
        end
    end

    assign MCU_RDY      = mcu_rdy_q;
    assign MCU_DINR     = mcu_dinr_q;
    assign SNES_DOUT    = snes_dout_q;
    assign ROM_ADDR     = rom_addr_q;
    assign ROM_DATA_OUT = rom_dout_q;
    assign ROM_DATA_OE  = doe_q;
    assign ROM_CE       = ce_q;
    assign ROM_OE       = oe_q;
    assign ROM_WE       = we_q;
    assign ROM_BHE      = bhe_q;
    assign ROM_BLE      = ble_q;

endmodule

// File: tb/tb_rom_access_ctrl.sv
// Directed bench for rom_access_ctrl: a table of single SNES accesses plus
// hand-written arbitration and reset sequences.
module tb_rom_access_ctrl;

    logic        CLK, RST, SNES_READ, SNES_WRITE, ROM_HIT, IS_WRITABLE, MCU_RRQ, MCU_WRQ;
    logic [7:0]  SNES_DATA_IN, MCU_DOUT;
    logic [23:0] ADDR_IN, MCU_ADDR;
    logic [15:0] ROM_DATA_IN;
    logic        MCU_RDY, ROM_DATA_OE, ROM_CE, ROM_OE, ROM_WE, ROM_BHE, ROM_BLE;
    logic [7:0]  MCU_DINR, SNES_DOUT;
    logic [22:0] ROM_ADDR;
    logic [15:0] ROM_DATA_OUT;

    rom_access_ctrl dut (
        .CLK(CLK), .RST(RST), .SNES_READ(SNES_READ), .SNES_WRITE(SNES_WRITE),
        .SNES_DATA_IN(SNES_DATA_IN), .ADDR_IN(ADDR_IN), .ROM_HIT(ROM_HIT),
        .IS_WRITABLE(IS_WRITABLE), .MCU_ADDR(MCU_ADDR), .MCU_DOUT(MCU_DOUT),
        .MCU_RRQ(MCU_RRQ), .MCU_WRQ(MCU_WRQ), .MCU_RDY(MCU_RDY), .MCU_DINR(MCU_DINR),
        .SNES_DOUT(SNES_DOUT), .ROM_ADDR(ROM_ADDR), .ROM_DATA_IN(ROM_DATA_IN),
        .ROM_DATA_OUT(ROM_DATA_OUT), .ROM_DATA_OE(ROM_DATA_OE), .ROM_CE(ROM_CE),
        .ROM_OE(ROM_OE), .ROM_WE(ROM_WE), .ROM_BHE(ROM_BHE), .ROM_BLE(ROM_BLE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        wr;
        logic        hit;
        logic        wbl;
        logic [23:0] addr;
        logic [7:0]  data;
        logic [15:0] din;
        logic        active;
        logic [22:0] exp_addr;
        logic        exp_bhe;
        logic        exp_ble;
        logic [15:0] exp_dout16;
        int          exp_cyc;
        logic [7:0]  exp_snes_dout;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   k;
        int   len;
        logic bad;
        ADDR_IN = v.addr; SNES_DATA_IN = v.data; ROM_HIT = v.hit;
        IS_WRITABLE = v.wbl; ROM_DATA_IN = v.din;
        if (v.wr) SNES_WRITE = 1'b0;
        else      SNES_READ  = 1'b0;
        k = 0;
        while (ROM_CE && k < 12) begin
            tick();
            k++;
        end
        if (!v.active) begin
            check($sformatf("v%0d_no_activity", idx), {ROM_CE, ROM_OE, ROM_WE}, 3'b111);
        end else begin
            check($sformatf("v%0d_start_latency", idx), k, 4);
            check($sformatf("v%0d_rom_addr", idx), ROM_ADDR, v.exp_addr);
            check($sformatf("v%0d_bhe_ble", idx), {ROM_BHE, ROM_BLE}, {v.exp_bhe, v.exp_ble});
            check($sformatf("v%0d_oe_we_doe", idx), {ROM_OE, ROM_WE, ROM_DATA_OE}, {v.wr, ~v.wr, v.wr});
            if (v.wr) check($sformatf("v%0d_data_out", idx), ROM_DATA_OUT, v.exp_dout16);
            len = 0;
            bad = 1'b0;
            while (!ROM_CE && len < 20) begin
                if (ROM_OE != v.wr || ROM_WE != !v.wr || ROM_DATA_OE != v.wr || ROM_ADDR != v.exp_addr)
                    bad = 1'b1;
                tick();
                len++;
            end
            check($sformatf("v%0d_cycle_len", idx), len, v.exp_cyc);
            check($sformatf("v%0d_stable", idx), bad, 0);
            check($sformatf("v%0d_idle_strobes", idx), {ROM_CE, ROM_OE, ROM_WE, ROM_DATA_OE}, 4'b1110);
        end
        check($sformatf("v%0d_snes_dout", idx), SNES_DOUT, v.exp_snes_dout);
        SNES_READ = 1'b1; SNES_WRITE = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   len;
        logic bad;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 24'h012345, 8'h00, 16'hA55A, 1'b1, 23'h0091A2, 1'b1, 1'b0, 16'h0000, 7, 8'h5A};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 24'hE00000, 8'h3C, 16'h0000, 1'b1, 23'h700000, 1'b0, 1'b1, 16'h3C3C, 6, 8'h5A};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 24'h000444, 8'h77, 16'h0000, 1'b0, 23'h000000, 1'b1, 1'b1, 16'h0000, 0, 8'h5A};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 24'h000555, 8'h00, 16'hFFFF, 1'b0, 23'h000000, 1'b1, 1'b1, 16'h0000, 0, 8'h5A};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 24'h000100, 8'h00, 16'h1234, 1'b1, 23'h000080, 1'b0, 1'b1, 16'h0000, 7, 8'h12};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 24'h7FFFFF, 8'hA7, 16'h0000, 1'b1, 23'h3FFFFF, 1'b1, 1'b0, 16'hA7A7, 6, 8'h12};

        RST = 1'b1; SNES_READ = 1'b1; SNES_WRITE = 1'b1; SNES_DATA_IN = 8'h00;
        ADDR_IN = '0; ROM_HIT = 1'b0; IS_WRITABLE = 1'b0; MCU_ADDR = '0; MCU_DOUT = 8'h00;
        MCU_RRQ = 1'b0; MCU_WRQ = 1'b0; ROM_DATA_IN = 16'h0000;
        repeat (3) tick();
        RST = 1'b0;
        tick();

        check("rst_strobes", {ROM_CE, ROM_OE, ROM_WE, ROM_BHE, ROM_BLE, ROM_DATA_OE}, 6'b111110);
        check("rst_rom_addr", ROM_ADDR, 23'h0);
        check("rst_snes_dout", SNES_DOUT, 8'h00);
        check("rst_mcu_dinr", MCU_DINR, 8'h00);
        check("rst_mcu_rdy", MCU_RDY, 1'b1);
        repeat (4) tick();

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // SNES read and MCU read request land in the same cycle.
        ADDR_IN = 24'h000201; ROM_HIT = 1'b1; IS_WRITABLE = 1'b0; ROM_DATA_IN = 16'hBEEF;
        MCU_ADDR = 24'h000010;
        SNES_READ = 1'b0;
        repeat (3) tick();
        MCU_RRQ = 1'b1;
        tick();
        MCU_RRQ = 1'b0;
        check("col_snes_first_ce_oe", {ROM_CE, ROM_OE}, 2'b00);
        check("col_snes_first_addr", ROM_ADDR, 23'h000100);
        check("col_rdy_low", MCU_RDY, 1'b0);
        len = 0;
        while (!ROM_CE && len < 20) begin tick(); len++; end
        check("col_snes_len", len, 7);
        check("col_snes_dout", SNES_DOUT, 8'hEF);
        check("col_gap_rdy_low", MCU_RDY, 1'b0);
        tick();
        check("col_mcu_start", {ROM_CE, ROM_OE, ROM_BHE, ROM_BLE}, 4'b0001);
        check("col_mcu_addr", ROM_ADDR, 23'h000008);
        len = 0;
        while (!ROM_CE && len < 20) begin
            check("col_mcu_rdy_busy", MCU_RDY, 1'b0);
            tick();
            len++;
        end
        check("col_mcu_len", len, 7);
        check("col_mcu_dinr", MCU_DINR, 8'hBE);
        check("col_mcu_rdy_done", MCU_RDY, 1'b1);
        SNES_READ = 1'b1;
        repeat (5) tick();

        // SNES write arriving while an MCU write is running.
        MCU_ADDR = 24'h000021; MCU_DOUT = 8'h5C; MCU_WRQ = 1'b1;
        tick();
        MCU_WRQ = 1'b0;
        k = 0;
        while (ROM_CE && k < 10) begin tick(); k++; end
        check("q_mcu_start_latency", k, 1);
        check("q_mcu_wr_strobes", {ROM_WE, ROM_OE, ROM_DATA_OE, ROM_BHE, ROM_BLE}, 5'b01110);
        check("q_mcu_addr", ROM_ADDR, 23'h000010);
        check("q_mcu_data_out", ROM_DATA_OUT, 16'h5C5C);
        ADDR_IN = 24'h400002; SNES_DATA_IN = 8'h99; ROM_HIT = 1'b1; IS_WRITABLE = 1'b1;
        bad = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 1) SNES_WRITE = 1'b0;
            if (i == 5) begin
                ADDR_IN = 24'hFFFFFF; SNES_DATA_IN = 8'h00; ROM_HIT = 1'b0; IS_WRITABLE = 1'b0;
            end
            if (ROM_CE || ROM_WE || ROM_ADDR != 23'h000010) bad = 1'b1;
        end
        check("q_mcu_uninterrupted", bad, 1'b0);
        tick();
        check("q_gap_idle", {ROM_CE, ROM_WE}, 2'b11);
        check("q_gap_rdy", MCU_RDY, 1'b1);
        tick();
        check("q_snes_wr_start", {ROM_CE, ROM_WE, ROM_DATA_OE, ROM_BHE, ROM_BLE}, 5'b00101);
        check("q_snes_addr", ROM_ADDR, 23'h200001);
        check("q_snes_data_out", ROM_DATA_OUT, 16'h9999);
        len = 0;
        while (!ROM_CE && len < 20) begin tick(); len++; end
        check("q_snes_len", len, 6);
        SNES_WRITE = 1'b1;
        repeat (5) tick();

        // Reset in the third cycle of a SNES read.
        ADDR_IN = 24'h000003; ROM_HIT = 1'b1; ROM_DATA_IN = 16'h1111;
        SNES_READ = 1'b0;
        k = 0;
        while (ROM_CE && k < 12) begin tick(); k++; end
        check("r_read_started", ROM_CE, 1'b0);
        tick();
        tick();
        RST = 1'b1;
        SNES_READ = 1'b1;
        tick();
        check("r_strobes", {ROM_CE, ROM_OE, ROM_WE, ROM_BHE, ROM_BLE, ROM_DATA_OE}, 6'b111110);
        check("r_mcu_rdy", MCU_RDY, 1'b1);
        check("r_snes_dout", SNES_DOUT, 8'h00);
        check("r_rom_addr", ROM_ADDR, 23'h0);
        RST = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            tick();
            if (!ROM_CE) bad = 1'b1;
        end
        check("r_quiet_after", bad, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_access_ctrl.md
Name: rom_access_ctrl

Overview:
- Sequencer directly downstream of the address decoder. Consumes the decoder's translated ROM address plus its ROM_HIT and IS_WRITABLE outputs.
- Turns SNES bus strobes and MCU byte requests into timed cycles on the 16-bit cartridge PSRAM ("SRAM0").
- Arbitrates SNES against MCU, with SNES priority.
- Latches read data back to the SNES data path and the MCU.

Parameters:
- RD_CYCLES, 7, CLK cycles ROM_OE is held low per read; data is sampled on the last one.
- WR_CYCLES, 6, CLK cycles ROM_WE is held low per write.
- SYNC_DEPTH, 3, synchroniser length for SNES_READ/SNES_WRITE (minimum 2).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- SNES_READ  in  1  SNES read strobe, active-low, asynchronous
- SNES_WRITE  in  1  SNES write strobe, active-low, asynchronous
- SNES_DATA_IN  in  8  SNES write data
- ADDR_IN  in  24  translated byte address from the decoder (ROM_ADDR)
- ROM_HIT  in  1  decoder: access targets PSRAM
- IS_WRITABLE  in  1  decoder: target is writable
- MCU_ADDR  in  24  MCU byte address
- MCU_DOUT  in  8  MCU write data
- MCU_RRQ  in  1  MCU read request pulse
- MCU_WRQ  in  1  MCU write request pulse
- MCU_RDY  out  1  high when no MCU request is pending or active
- MCU_DINR  out  8  MCU read data
- SNES_DOUT  out  8  latched PSRAM byte for the SNES
- ROM_ADDR  out  23  PSRAM word address (byte address [23:1])
- ROM_DATA_IN  in  16  PSRAM read data
- ROM_DATA_OUT  out  16  PSRAM write data (byte duplicated on both halves)
- ROM_DATA_OE  out  1  drive ROM data bus
- ROM_CE  out  1  active-low chip enable
- ROM_OE  out  1  active-low output enable
- ROM_WE  out  1  active-low write enable
- ROM_BHE  out  1  active-low upper byte enable
- ROM_BLE  out  1  active-low lower byte enable

Behaviour:
- Reset values: ROM_CE/OE/WE/BHE/BLE=1; ROM_DATA_OE=0; ROM_ADDR=0; SNES_DOUT=8'h00; MCU_DINR=8'h00; MCU_RDY=1; FSM=IDLE; pending flags cleared. Reset mid-cycle aborts immediately with the same values; a partial write is acceptable.
- Strobe synchronisation: each SNES strobe passes through a SYNC_DEPTH shift register. An assert event is the synced 1->0 transition, one CLK wide.
- Request qualification: a read event requests a cycle only if ROM_HIT=1. A write event requires ROM_HIT=1 and IS_WRITABLE=1. ADDR_IN and SNES_DATA_IN are captured on the event cycle. Unqualified events are ignored.
- Byte lanes: addr[0]=0 selects the upper byte (BHE=0, BLE=1, data [15:8]); addr[0]=1 selects the lower byte. ROM_DATA_OUT={byte,byte}.
- FSM states: IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR.
  - IDLE -> SNES_* on a qualified SNES event or a pending SNES flag.
  - Otherwise IDLE -> MCU_* if an MCU flag is pending.
  - Each cycle state loads a down-counter with RD_CYCLES-1 or WR_CYCLES-1 and returns to IDLE when the counter reaches 0.
- Strobe timing: ROM_CE, the selected byte enable, and ROM_OE or ROM_WE go low in the first state cycle and high on return to IDLE. ROM_ADDR is stable for the whole state. ROM_DATA_OE=1 during write states only.
- Read data: the selected byte of ROM_DATA_IN is latched on the last read cycle into SNES_DOUT or MCU_DINR. Latency from the SNES event to a valid SNES_DOUT is RD_CYCLES+1 CLK.
- Arbitration:
  - A qualified SNES event arriving during an MCU cycle sets the SNES pending flag (address and data captured). It is serviced on the cycle after that MCU cycle ends.
  - A second SNES event while one is already pending overwrites it.
  - SNES and MCU events in the same cycle: SNES wins; the MCU request stays pending.
- MCU handshake: an RRQ/WRQ pulse latches the address/data and sets pending, and MCU_RDY drops the next cycle. MCU_RDY rises the cycle after the MCU state returns to IDLE. Requests while MCU_RDY=0 are ignored. RRQ and WRQ together: WRQ is taken.
- Counter: 4 bits. RD_CYCLES and WR_CYCLES must be in 2..15, enforced by an elaboration-time check.

Optional Feature:
- Macro: ROM_STROBE_FILTER_EN.
- Defined: an assert event additionally requires the strobe to be low for 2 consecutive synced samples. This rejects single-sample glitches and adds 1 CLK of latency.
- Undefined: single-edge detection as above.

Decomposition:
- Shared package holds the FSM state enum, the default cycle constants, and the byte-lane select helper function.
- One natural sub-module, snes_strobe_sync: synchroniser, edge detector, and optional filter, instantiated once per strobe.

Test Plan:
- Read path: SNES_READ falls with ADDR_IN=24'h012345, ROM_HIT=1, ROM_DATA_IN=16'hA55A -> ROM_ADDR=23'h0091A2; BLE=0, BHE=1; OE low exactly 7 CLK; SNES_DOUT=8'h5A at 8 CLK after the synced edge.
- Write path: SNES_WRITE falls with IS_WRITABLE=1, ADDR_IN=24'hE00000, data 8'h3C -> WE low 6 CLK, BHE=0, ROM_DATA_OUT=16'h3C3C, DATA_OE high only during WE.
- Write protect: write with IS_WRITABLE=0, and a read with ROM_HIT=0 -> no CE/OE/WE activity; outputs unchanged.
- Collision: MCU_RRQ at 24'h000010 and a SNES read edge in the same cycle -> SNES cycle first, MCU cycle starts 1 CLK after; MCU_RDY stays 0 until the MCU read completes.
- SNES queued behind MCU: SNES write edge 2 CLK into an MCU write -> MCU write completes; the SNES write starts next CLK with the captured address and data.
- Reset mid-read: RST at CLK 3 of SNES_RD -> next cycle all strobes 1, FSM IDLE, MCU_RDY=1, SNES_DOUT=8'h00.
